cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among up to NUM_REQ functional units (ALU, branch, multiply, divide) with round-robin arbitration.
- Holds each losing FU's result in a one-entry holding slot and back-pressures that FU through `stall_fu`.
- Its `stall_fu` vector drives the `stall_fu` inputs of the reservation stations, so issue stops exactly when a unit's writeback path is blocked.
- Sits between the FU output stages and the CDB consumers (ROB, PRF write port, reservation-station wakeup).

---
 rtl/rv32i_types.sv | 18 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/cdb_arbiter.sv | 71 +++++++
 tb/tb_cdb_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared core types for CDB broadcast and functional-unit indexing
package rv32i_types;
  localparam int PHYS_WIDTH    = 6;
  localparam int ROB_IDX_WIDTH = 5;
  localparam int FU_DIV = 0;
  localparam int FU_MUL = 1;
  localparam int FU_BR  = 2;
  localparam int FU_ALU = 3;
  typedef struct packed {
    logic                     valid;
    logic [PHYS_WIDTH-1:0]    pd_addr;
    logic [4:0]               rd_addr;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    logic [31:0]              data;
    logic                     br_taken;
    logic [31:0]              br_target;
  } cdb_pkt;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from ptr+1 with wraparound
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] win,
  output logic          win_valid
);
  logic [PW-1:0] idx;
  // scan farthest offset first so the nearest requester after ptr is the last write
  always_comb begin
    win = '0;
    win_valid = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        win = idx;
        win_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of the common data bus with one-entry holding slots per FU
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] fu_valid,
  input  cdb_pkt             fu_pkt [NUM_REQ],
  input  logic               br_flush,
  output logic [NUM_REQ-1:0] stall_fu,
  output cdb_pkt             cdb_out,
  output logic [NUM_REQ-1:0] grant_vec,
  output logic [31:0]        stall_cycles
);
  localparam int PTR_WIDTH = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]   hold_valid, req, gnt, hold_nxt;
  cdb_pkt               hold_pkt [NUM_REQ];
  cdb_pkt               cand [NUM_REQ];
  cdb_pkt               win_pkt;
  logic [PTR_WIDTH-1:0] rr_ptr, win;
  logic                 win_valid;

  assign req      = hold_valid | (fu_valid & ~hold_valid);
  assign stall_fu = hold_valid;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req),
    .ptr       (rr_ptr),
    .win       (win),
    .win_valid (win_valid)
  );

  // held results take precedence over the FU's live output; losers stay or become held
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) cand[i] = hold_valid[i] ? hold_pkt[i] : fu_pkt[i];
    gnt = win_valid ? NUM_REQ'(1) << win : '0;
    hold_nxt = req & ~gnt;
    win_pkt = cand[win];
    win_pkt.valid = 1'b1;
  end

  // broadcast register, holding slots, pointer and stall counter; flush drops everything pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) hold_pkt[i] <= '0;
      cdb_out <= '0;
      grant_vec <= '0;
      rr_ptr <= PTR_WIDTH'(NUM_REQ - 1);
      stall_cycles <= '0;
    end else if (br_flush) begin
      hold_valid <= '0;
      cdb_out.valid <= 1'b0;
      grant_vec <= '0;
    end else begin
      hold_valid <= hold_nxt;
      for (int i = 0; i < NUM_REQ; i++)
        if (fu_valid[i] && !hold_valid[i] && !gnt[i]) hold_pkt[i] <= fu_pkt[i];
      if (win_valid) begin
        cdb_out <= win_pkt;
        rr_ptr <= win;
      end else begin
        cdb_out.valid <= 1'b0;
      end
      grant_vec <= gnt;
      stall_cycles <= stall_cycles + 32'(|hold_valid);
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random checks of cdb_arbiter against a distance-based reference model
module tb_cdb_arbiter;
  import rv32i_types::*;
  localparam int N = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         br_flush = 1'b0;
  logic [N-1:0] fu_valid = '0;
  cdb_pkt       fu_pkt [N];
  logic [N-1:0] stall_fu, grant_vec;
  cdb_pkt       cdb_out;
  logic [31:0]  stall_cycles;
  int vectors = 0, checks = 0, miscompares = 0;
  logic [N-1:0] m_hold;
  cdb_pkt       m_hpkt [N];
  int           m_last;
  cdb_pkt       m_cdb;
  logic [N-1:0] m_grant;
  logic [31:0]  m_stall;
  int           n1;
  cdb_pkt       p_saved;

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fu_valid     (fu_valid),
    .fu_pkt       (fu_pkt),
    .br_flush     (br_flush),
    .stall_fu     (stall_fu),
    .cdb_out      (cdb_out),
    .grant_vec    (grant_vec),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic cdb_pkt rand_pkt();
    cdb_pkt p;
    p.valid     = 1'b1;
    p.pd_addr   = PHYS_WIDTH'($urandom);
    p.rd_addr   = 5'($urandom);
    p.rob_idx   = ROB_IDX_WIDTH'($urandom);
    p.data      = $urandom;
    p.br_taken  = 1'($urandom);
    p.br_target = $urandom;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_hold = '0;
    for (int i = 0; i < N; i++) m_hpkt[i] = '0;
    m_last = N - 1;
    m_cdb = '0;
    m_grant = '0;
    m_stall = '0;
  endtask

  // each pending result is served in order of its circular distance past the last winner
  task automatic m_edge();
    logic [N-1:0] pend;
    cdb_pkt pk [N];
    int best, bestd, d;
    bit any;
    if (br_flush) begin
      m_hold = '0;
      m_cdb.valid = 1'b0;
      m_grant = '0;
      return;
    end
    any = (m_hold != 0);
    best = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      pend[i] = m_hold[i] | fu_valid[i];
      pk[i] = m_hold[i] ? m_hpkt[i] : fu_pkt[i];
      d = (i - m_last - 1 + 2 * N) % N;
      if (pend[i] && d < bestd) begin
        best = i;
        bestd = d;
      end
    end
    if (best >= 0) begin
      m_cdb = pk[best];
      m_cdb.valid = 1'b1;
      m_grant = N'(1) << best;
      m_last = best;
    end else begin
      m_cdb.valid = 1'b0;
      m_grant = '0;
    end
    for (int i = 0; i < N; i++) begin
      m_hold[i] = pend[i] && (i != best);
      if (m_hold[i]) m_hpkt[i] = pk[i];
    end
    if (any) m_stall = m_stall + 1;
  endtask

  task automatic check_outputs();
    chk("cdb_valid", 128'(cdb_out.valid), 128'(m_cdb.valid));
    if (m_cdb.valid) chk("cdb_pkt", 128'(cdb_out), 128'(m_cdb));
    chk("grant_vec", 128'(grant_vec), 128'(m_grant));
    chk("stall_fu", 128'(stall_fu), 128'(m_hold));
    chk("stall_cycles", 128'(stall_cycles), 128'(m_stall));
  endtask

  task automatic step();
    vectors++;
    @(posedge clk);
    #1;
    m_edge();
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    check_outputs();
    chk("rst_cdb_zero", 128'(cdb_out), 128'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] exp_st [4];
    exp_st = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    for (int i = 0; i < N; i++) fu_pkt[i] = '0;
    #2;
    m_reset();
    check_outputs();
    chk("rst_cdb_zero", 128'(cdb_out), 128'(0));
    #10;
    rst_n = 1'b1;
    step();
    // single FU
    fu_pkt[1] = rand_pkt();
    fu_pkt[1].pd_addr = 6'd7;
    fu_valid = 4'b0010;
    step();
    chk("single_pd", 128'(cdb_out.pd_addr), 128'(7));
    chk("single_grant", 128'(grant_vec), 128'(4'b0010));
    chk("single_stall", 128'(stall_fu), 128'(0));
    fu_valid = '0;
    step();
    // four-way collision
    do_reset();
    for (int i = 0; i < N; i++) fu_pkt[i] = rand_pkt();
    fu_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      fu_valid = '0;
      chk("coll_grant", 128'(grant_vec), 128'(N'(1) << k));
      chk("coll_stall", 128'(stall_fu), 128'(exp_st[k]));
    end
    chk("coll_stall_cycles", 128'(stall_cycles), 128'(3));
    step();
    // fairness between FU3 and FU0
    do_reset();
    fu_valid = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) if (!m_hold[i]) fu_pkt[i] = rand_pkt();
      step();
      chk("fair_grant", 128'(grant_vec), 128'((k % 2 == 0) ? 4'b0001 : 4'b1000));
    end
    fu_valid = '0;
    step();
    step();
    // flush discards held packets
    do_reset();
    for (int i = 0; i < N; i++) fu_pkt[i] = rand_pkt();
    fu_valid = 4'b0111;
    step();
    chk("flush_pre_stall", 128'(stall_fu), 128'(4'b0110));
    fu_valid = '0;
    br_flush = 1'b1;
    step();
    chk("flush_stall", 128'(stall_fu), 128'(0));
    chk("flush_valid", 128'(cdb_out.valid), 128'(0));
    br_flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_no_bcast", 128'(cdb_out.valid), 128'(0));
    end
    // stall protocol: FU1 toggles its valid while held
    do_reset();
    fu_pkt[1] = rand_pkt();
    fu_valid = 4'b0010;
    step();
    for (int i = 0; i < N; i++) fu_pkt[i] = rand_pkt();
    p_saved = fu_pkt[1];
    fu_valid = 4'b1111;
    n1 = 0;
    step();
    n1 += int'(grant_vec[1]);
    for (int k = 0; k < 3; k++) begin
      fu_pkt[1] = rand_pkt();
      fu_valid = (k == 1) ? 4'b0000 : 4'b0010;
      step();
      n1 += int'(grant_vec[1]);
      if (k == 2) chk("stall_held_data", 128'(cdb_out.data), 128'(p_saved.data));
    end
    fu_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      n1 += int'(grant_vec[1]);
    end
    chk("stall_once", 128'(n1), 128'(1));
    // asynchronous reset mid-cycle with holds pending
    for (int i = 0; i < N; i++) fu_pkt[i] = rand_pkt();
    fu_valid = 4'b1111;
    step();
    fu_valid = '0;
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_outputs();
    chk("async_cdb_zero", 128'(cdb_out), 128'(0));
    #2;
    rst_n = 1'b1;
    fu_valid = 4'b1111;
    step();
    chk("async_first_fu0", 128'(grant_vec), 128'(4'b0001));
    fu_valid = '0;
    for (int k = 0; k < 4; k++) step();
    // random traffic
    for (int k = 0; k < 400; k++) begin
      fu_valid = N'($urandom);
      for (int i = 0; i < N; i++) if (!m_hold[i] || $urandom_range(0, 3) == 0) fu_pkt[i] = rand_pkt();
      br_flush = ($urandom_range(0, 19) == 0);
      step();
    end
    br_flush = 1'b0;
    fu_valid = '0;
    for (int k = 0; k < 5; k++) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
